// File: rtl/grayscale_convert_pkg.sv
// Shared constants for the in-place BMP grayscale stage: RAM geometry, BMP layout
// and Q0.8 luma weights.
package grayscale_convert_pkg;
  localparam int unsigned DEF_BYTE_WIDTH      = 8;
  localparam int unsigned DEF_ADDR_WIDTH      = 20;
  localparam int unsigned DEF_BMP_HEADER_SIZE = 54;
  localparam int unsigned DEF_BMP_TOTAL_SIZE  = 54 + 3 * 4 * 4;
  localparam int unsigned DEF_COEF_R          = 77;
  localparam int unsigned DEF_COEF_G          = 150;
  localparam int unsigned DEF_COEF_B          = 29;
endpackage

// File: rtl/grayscale_convert_if.sv
// Start request, shared byte-wide RAM port and completion flag of the grayscale stage.
interface grayscale_convert_if
  import grayscale_convert_pkg::*;
#(
  parameter int unsigned BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  in_valid;
  logic [BYTE_WIDTH-1:0] RAM_out;
  logic                  RAM_ren;
  logic                  RAM_wen;
  logic [BYTE_WIDTH-1:0] RAM_in;
  logic [ADDR_WIDTH-1:0] RAM_addr;
  logic                  gray_done;

  modport slave (
    input  in_valid, RAM_out,
    output RAM_ren, RAM_wen, RAM_in, RAM_addr, gray_done
  );

  modport master (
    output in_valid, RAM_out,
    input  RAM_ren, RAM_wen, RAM_in, RAM_addr, gray_done
  );
endinterface

// File: rtl/grayscale_convert_gray_luma.sv
// Combinational luma: weighted Q0.8 sum of R, G, B, truncated to the upper byte.
module gray_luma
  import grayscale_convert_pkg::*;
#(
  parameter int unsigned COEF_R = DEF_COEF_R,
  parameter int unsigned COEF_G = DEF_COEF_G,
  parameter int unsigned COEF_B = DEF_COEF_B
) (
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] gray
);
  logic [15:0] w_sum;

  // Weights total 256, so the 16-bit sum cannot overflow.
  always_comb begin
    w_sum = 16'(COEF_R) * 16'(r) + 16'(COEF_G) * 16'(g) + 16'(COEF_B) * 16'(b);
    gray  = w_sum[15:8];
  end
endmodule

// File: rtl/grayscale_convert.sv
// Walks the pixel area of a 24-bit BMP in RAM, replacing each B,G,R triple with its luma.
module grayscale_convert
  import grayscale_convert_pkg::*;
#(
  parameter int unsigned BYTE_WIDTH      = DEF_BYTE_WIDTH,
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned BMP_HEADER_SIZE = DEF_BMP_HEADER_SIZE,
  parameter int unsigned BMP_TOTAL_SIZE  = DEF_BMP_TOTAL_SIZE,
  parameter int unsigned COEF_R          = DEF_COEF_R,
  parameter int unsigned COEF_G          = DEF_COEF_G,
  parameter int unsigned COEF_B          = DEF_COEF_B
) (
  input logic               clk,
  input logic               rst,
  grayscale_convert_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_RD0 = 4'd1, S_RD1 = 4'd2, S_RD2 = 4'd3, S_CALC = 4'd4,
    S_WR0  = 4'd5, S_WR1 = 4'd6, S_WR2 = 4'd7, S_DONE = 4'd8
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] HDR_ADDR = ADDR_WIDTH'(BMP_HEADER_SIZE);
  localparam logic [ADDR_WIDTH-1:0] END_ADDR = ADDR_WIDTH'(BMP_TOTAL_SIZE);

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_p, w_p_next, w_base, r_addr, w_addr_next;
  logic [BYTE_WIDTH-1:0] r_b, r_g, r_gray, w_gray, r_din, w_din_next;
  logic                  r_ren, r_wen, r_done, w_ren_next, w_wen_next;

  gray_luma #(
    .COEF_R (COEF_R),
    .COEF_G (COEF_G),
    .COEF_B (COEF_B)
  ) u_luma (
    .r    (bus.RAM_out),
    .g    (r_g),
    .b    (r_b),
    .gray (w_gray)
  );

  assign w_p_next = r_p + ADDR_WIDTH'(3);
  // Outputs are registered, so the address is formed for the state being entered.
  assign w_base   = (r_state == S_WR2) ? w_p_next : r_p;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid && !r_done) w_state_next = S_RD0;
      S_RD0:   w_state_next = S_RD1;
      S_RD1:   w_state_next = S_RD2;
      S_RD2:   w_state_next = S_CALC;
      S_CALC:  w_state_next = S_WR0;
      S_WR0:   w_state_next = S_WR1;
      S_WR1:   w_state_next = S_WR2;
      S_WR2:   w_state_next = (w_p_next >= END_ADDR) ? S_DONE : S_RD0;
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase

    w_ren_next  = 1'b0;
    w_wen_next  = 1'b0;
    w_addr_next = HDR_ADDR;
    w_din_next  = '0;
    case (w_state_next)
      S_RD0: begin w_ren_next = 1'b1; w_addr_next = w_base; end
      S_RD1: begin w_ren_next = 1'b1; w_addr_next = w_base + ADDR_WIDTH'(1); end
      S_RD2: begin w_ren_next = 1'b1; w_addr_next = w_base + ADDR_WIDTH'(2); end
      S_WR0, S_WR1, S_WR2: begin
        w_wen_next = 1'b1;
        w_din_next = (r_state == S_CALC) ? w_gray : r_gray;
        case (w_state_next)
          S_WR0:   w_addr_next = w_base;
          S_WR1:   w_addr_next = w_base + ADDR_WIDTH'(1);
          default: w_addr_next = w_base + ADDR_WIDTH'(2);
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_p     <= HDR_ADDR;
      r_b     <= '0;
      r_g     <= '0;
      r_gray  <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= HDR_ADDR;
      r_din   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ren   <= w_ren_next;
      r_wen   <= w_wen_next;
      r_addr  <= w_addr_next;
      r_din   <= w_din_next;
      if (r_state == S_RD1)  r_b    <= bus.RAM_out;
      if (r_state == S_RD2)  r_g    <= bus.RAM_out;
      if (r_state == S_CALC) r_gray <= w_gray;
      if (r_state == S_WR2)  r_p    <= w_p_next;
      // Flag follows DONE by one cycle, giving the 7N+1 completion latency.
      r_done  <= r_done | (r_state == S_DONE);
    end
  end

  assign bus.RAM_ren   = r_ren;
  assign bus.RAM_wen   = r_wen;
  assign bus.RAM_addr  = r_addr;
  assign bus.RAM_in    = r_din;
  assign bus.gray_done = r_done;
endmodule

// File: tb/tb_grayscale_convert.sv
// Directed bench: a 1-pixel and a 16-pixel image in bench-side RAMs, checked against
// hand-computed luma values and the per-pixel access order.
module tb_grayscale_convert;
  localparam int unsigned HDR   = 54;
  localparam int unsigned TOT_A = 57;
  localparam int unsigned TOT_B = 102;
  localparam int unsigned NPIX  = 16;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] gray;
  } pix_t;

  pix_t vec [NPIX];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, load;
  logic mon_en = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  int   hdr_hits = 0;

  grayscale_convert_if #(.BYTE_WIDTH(8), .ADDR_WIDTH(20)) bus_a();
  grayscale_convert_if #(.BYTE_WIDTH(8), .ADDR_WIDTH(20)) bus_b();

  grayscale_convert #(
    .BYTE_WIDTH(8), .ADDR_WIDTH(20), .BMP_HEADER_SIZE(HDR), .BMP_TOTAL_SIZE(TOT_A),
    .COEF_R(77), .COEF_G(150), .COEF_B(29)
  ) u_dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

  grayscale_convert #(
    .BYTE_WIDTH(8), .ADDR_WIDTH(20), .BMP_HEADER_SIZE(HDR), .BMP_TOTAL_SIZE(TOT_B),
    .COEF_R(77), .COEF_G(150), .COEF_B(29)
  ) u_dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  logic [7:0] mem_a [TOT_A];
  logic [7:0] init_a [TOT_A];
  logic [7:0] mem_b [TOT_B];
  logic [7:0] init_b [TOT_B];
  logic [7:0] rd_a = 8'h00;
  logic [7:0] rd_b = 8'h00;

  assign bus_a.RAM_out = rd_a;
  assign bus_b.RAM_out = rd_b;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < TOT_A; i++) mem_a[i] <= init_a[i];
      for (int i = 0; i < TOT_B; i++) mem_b[i] <= init_b[i];
    end else begin
      if (bus_a.RAM_wen && int'(bus_a.RAM_addr) < TOT_A) mem_a[int'(bus_a.RAM_addr)] <= bus_a.RAM_in;
      if (bus_a.RAM_ren && int'(bus_a.RAM_addr) < TOT_A) rd_a <= mem_a[int'(bus_a.RAM_addr)];
      if (bus_b.RAM_wen && int'(bus_b.RAM_addr) < TOT_B) mem_b[int'(bus_b.RAM_addr)] <= bus_b.RAM_in;
      if (bus_b.RAM_ren && int'(bus_b.RAM_addr) < TOT_B) rd_b <= mem_b[int'(bus_b.RAM_addr)];
    end
    hdr_hits <= hdr_hits
              + int'((bus_a.RAM_ren || bus_a.RAM_wen) && int'(bus_a.RAM_addr) < HDR)
              + int'((bus_b.RAM_ren || bus_b.RAM_wen) && int'(bus_b.RAM_addr) < HDR);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("ren_wen_excl_a", 32'(bus_a.RAM_ren & bus_a.RAM_wen), 32'd0);
      check("ren_wen_excl_b", 32'(bus_b.RAM_ren & bus_b.RAM_wen), 32'd0);
    end
  end

  task automatic check_reset_b(input string name);
    check({name, "_ren"},  32'(bus_b.RAM_ren),   32'd0);
    check({name, "_wen"},  32'(bus_b.RAM_wen),   32'd0);
    check({name, "_din"},  32'(bus_b.RAM_in),    32'd0);
    check({name, "_addr"}, 32'(bus_b.RAM_addr),  32'd54);
    check({name, "_done"}, 32'(bus_b.gray_done), 32'd0);
  endtask

  task automatic check_image_b(input string name, input logic [7:0] pix3_gray);
    logic [7:0] g;
    int nmis;
    for (int p = 0; p < NPIX; p++) begin
      g = (p == 3) ? pix3_gray : vec[p].gray;
      check(name, {8'h00, mem_b[HDR+3*p], mem_b[HDR+3*p+1], mem_b[HDR+3*p+2]}, {8'h00, g, g, g});
    end
    nmis = 0;
    for (int i = 0; i < HDR; i++) if (mem_b[i] !== init_b[i]) nmis++;
    check({name, "_hdr"}, 32'(nmis), 32'd0);
  endtask

  initial begin
    vec[0]  = '{r:8'd255, g:8'd255, b:8'd255, gray:8'd255};
    vec[1]  = '{r:8'd0,   g:8'd0,   b:8'd0,   gray:8'd0};
    vec[2]  = '{r:8'd0,   g:8'd0,   b:8'd255, gray:8'd28};
    vec[3]  = '{r:8'd0,   g:8'd255, b:8'd0,   gray:8'd149};
    vec[4]  = '{r:8'd100, g:8'd150, b:8'd200, gray:8'd140};
    vec[5]  = '{r:8'd10,  g:8'd20,  b:8'd30,  gray:8'd18};
    vec[6]  = '{r:8'd200, g:8'd100, b:8'd50,  gray:8'd124};
    vec[7]  = '{r:8'd1,   g:8'd1,   b:8'd0,   gray:8'd0};
    vec[8]  = '{r:8'd0,   g:8'd2,   b:8'd0,   gray:8'd1};
    vec[9]  = '{r:8'd128, g:8'd64,  b:8'd32,  gray:8'd79};
    vec[10] = '{r:8'd3,   g:8'd250, b:8'd7,   gray:8'd148};
    vec[11] = '{r:8'd255, g:8'd255, b:8'd0,   gray:8'd226};
    vec[12] = '{r:8'd0,   g:8'd255, b:8'd255, gray:8'd178};
    vec[13] = '{r:8'd255, g:8'd0,   b:8'd255, gray:8'd105};
    vec[14] = '{r:8'd50,  g:8'd60,  b:8'd70,  gray:8'd58};
    vec[15] = '{r:8'd17,  g:8'd17,  b:8'd17,  gray:8'd17};

    for (int i = 0; i < HDR; i++) begin
      init_a[i] = 8'((i * 7 + 3) % 256);
      init_b[i] = 8'((i * 13 + 5) % 256);
    end
    init_a[54] = 8'd0; init_a[55] = 8'd0; init_a[56] = 8'd255;
    for (int p = 0; p < NPIX; p++) begin
      init_b[HDR+3*p]   = vec[p].b;
      init_b[HDR+3*p+1] = vec[p].g;
      init_b[HDR+3*p+2] = vec[p].r;
    end

    rst_a = 1'b1; rst_b = 1'b1; load = 1'b0;
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
    @(negedge clk);
    load = 1'b1; tick(); load = 1'b0; tick();

    check("rst_a_addr", 32'(bus_a.RAM_addr), 32'd54);
    check("rst_a_done", 32'(bus_a.gray_done), 32'd0);
    check_reset_b("rst_b");
    mon_en = 1'b1;
    rst_a = 1'b0; rst_b = 1'b0; tick();

    // 1-pixel image: done exactly 8 cycles after the sampling edge
    bus_a.in_valid = 1'b1; tick(); bus_a.in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) check("a_done_lat7", 32'(bus_a.gray_done), 32'd0);
      if (k == 8) check("a_done_lat8", 32'(bus_a.gray_done), 32'd1);
    end
    check("a_pix", {8'h00, mem_a[54], mem_a[55], mem_a[56]}, {8'h00, 8'd76, 8'd76, 8'd76});
    begin
      int nmis = 0;
      for (int i = 0; i < HDR; i++) if (mem_a[i] !== init_a[i]) nmis++;
      check("a_hdr", 32'(nmis), 32'd0);
    end

    // 16-pixel image: exact access order, in_valid toggling throughout
    bus_b.in_valid = 1'b1; tick();
    for (int i = 0; i < NPIX; i++) begin
      for (int j = 0; j < 7; j++) begin
        int unsigned p;
        if (i != 0 || j != 0) begin
          bus_b.in_valid = ~bus_b.in_valid;
          tick();
        end
        p = HDR + 3 * i;
        if (j < 3) begin
          check("proto_rd", {bus_b.RAM_ren, bus_b.RAM_wen}, 32'b10);
          check("proto_rd_addr", 32'(bus_b.RAM_addr), 32'(p + j));
        end else if (j == 3) begin
          check("proto_calc", {bus_b.RAM_ren, bus_b.RAM_wen}, 32'b00);
        end else begin
          check("proto_wr", {bus_b.RAM_ren, bus_b.RAM_wen}, 32'b01);
          check("proto_wr_addr", 32'(bus_b.RAM_addr), 32'(p + j - 4));
          check("proto_wr_data", 32'(bus_b.RAM_in), 32'(vec[i].gray));
        end
      end
    end
    tick(); check("b_done_lat112", 32'(bus_b.gray_done), 32'd0);
    tick(); check("b_done_lat113", 32'(bus_b.gray_done), 32'd1);
    check_image_b("b_pix", vec[3].gray);

    // sticky done, no RAM traffic, in_valid held high
    bus_b.in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      check("b_post_done", {bus_b.RAM_ren, bus_b.RAM_wen, bus_b.gray_done}, 32'b001);
    end

    // reset during WR1 of pixel 3, then reconvert from the partially written image
    bus_b.in_valid = 1'b0; rst_b = 1'b1; load = 1'b1; tick(); load = 1'b0; tick();
    rst_b = 1'b0; tick();
    bus_b.in_valid = 1'b1; tick(); bus_b.in_valid = 1'b0;
    repeat (26) tick();
    check("mid_wr1", {bus_b.RAM_wen, 12'h000, bus_b.RAM_addr}, {1'b1, 12'h000, 20'd64});
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    check_reset_b("mid_rst");
    check("mid_partial", {8'h00, mem_b[63], mem_b[64], mem_b[65]}, {8'h00, 8'd149, 8'd149, 8'd0});
    check("mid_pix0", {8'h00, mem_b[54], mem_b[55], mem_b[56]}, {8'h00, 8'd255, 8'd255, 8'd255});
    bus_b.in_valid = 1'b1; tick(); bus_b.in_valid = 1'b0;
    for (int k = 0; k < 200 && !bus_b.gray_done; k++) tick();
    check("rerun_done", 32'(bus_b.gray_done), 32'd1);
    check_image_b("rerun_pix", 8'd104);

    mon_en = 1'b0;
    check("hdr_access", 32'(hdr_hits), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
